// File: rtl/threadkraken_mmu_pkg.sv
// Shared types and helpers for the threadkraken MMU / external-bus unit.
package threadkraken_mmu_pkg;

  localparam int unsigned N_TRD = 8;
  localparam int unsigned TRD_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } mmu_state_e;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] limit;
    logic        valid;
  } seg_entry_t;

  // Replay result buffer; the D port keeps its store tag alongside.
  typedef struct packed {
    logic             valid;
    logic [TRD_W-1:0] trd;
    logic [31:0]      vaddr;
    logic [31:0]      data;
  } mmu_buf_t;

  function automatic logic seg_fault(input logic [31:0] limit, input logic valid,
                                     input logic [31:0] addr);
    return !valid || (addr > limit) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/threadkraken_mmu_seg.sv
// Per-thread base/limit segment register file with two lookup ports.
module mmu_seg_table
  import threadkraken_mmu_pkg::*;
#(
  parameter logic [31:0] BOOT_LIMIT = 32'hFFFF_FFFC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [TRD_W-1:0] wr_trd,
  input  logic [31:0]      wr_base,
  input  logic [31:0]      wr_limit,
  input  logic             wr_valid,
  input  logic [TRD_W-1:0] a_trd,
  input  logic [31:0]      a_addr,
  output logic             a_fault,
  output logic [31:0]      a_phys,
  input  logic [TRD_W-1:0] b_trd,
  input  logic [31:0]      b_addr,
  output logic             b_fault,
  output logic [31:0]      b_phys
);

  seg_entry_t seg [N_TRD];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < N_TRD; t++)
        seg[t] <= (t == 0) ? '{base: '0, limit: BOOT_LIMIT, valid: 1'b1} : '0;
    end else if (wr) begin
      seg[wr_trd] <= '{base: wr_base, limit: wr_limit, valid: wr_valid};
    end
  end

  always_comb begin
    a_fault = seg_fault(seg[a_trd].limit, seg[a_trd].valid, a_addr);
    a_phys  = seg[a_trd].base + a_addr;
    b_fault = seg_fault(seg[b_trd].limit, seg[b_trd].valid, b_addr);
    b_phys  = seg[b_trd].base + b_addr;
  end

endmodule

// File: rtl/threadkraken_mmu.sv
// Segment check, translation and single-outstanding external bus with
// miss-then-replay result buffers for the fetch and data ports.
module threadkraken_mmu
  import threadkraken_mmu_pkg::*;
#(
  parameter logic [31:0] BOOT_LIMIT = 32'hFFFF_FFFC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_addr,
  input  logic             i_rd,
  input  logic [TRD_W-1:0] i_trd,
  output logic [31:0]      i_rd_data,
  output logic             i_miss,
  output logic             i_segfault,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wr_data,
  input  logic             d_rd,
  input  logic             d_wr,
  input  logic [TRD_W-1:0] d_trd,
  output logic [31:0]      d_rd_data,
  output logic             d_miss,
  output logic             d_segfault,
  input  logic             cfg_wr,
  input  logic [TRD_W-1:0] cfg_trd,
  input  logic [31:0]      cfg_base,
  input  logic [31:0]      cfg_limit,
  input  logic             cfg_valid,
  output logic             ext_req,
  output logic             ext_we,
  output logic [31:0]      ext_addr,
  output logic [31:0]      ext_wdata,
  input  logic             ext_ack,
  input  logic [31:0]      ext_rdata
);

  mmu_state_e  state, state_nxt;
  mmu_buf_t    ibuf, dbuf;
  logic        dbuf_we;
  logic [31:0] dbuf_wdata;
  logic        drop, drop_nxt;
  logic        i_seg_fault, d_seg_fault;
  logic [31:0] i_phys, d_phys;
  logic        i_req, d_req, i_fault, d_fault, i_hit, d_hit;
  logic        i_launch, d_launch, i_kill, d_kill;

  mmu_seg_table #(.BOOT_LIMIT(BOOT_LIMIT)) u_seg (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (cfg_wr),
    .wr_trd   (cfg_trd),
    .wr_base  (cfg_base),
    .wr_limit (cfg_limit),
    .wr_valid (cfg_valid),
    .a_trd    (i_trd),
    .a_addr   (i_addr),
    .a_fault  (i_seg_fault),
    .a_phys   (i_phys),
    .b_trd    (d_trd),
    .b_addr   (d_addr),
    .b_fault  (d_seg_fault),
    .b_phys   (d_phys)
  );

  // Requests are masked during reset so every output reads 0 while rst_n is low.
  always_comb begin
    i_req      = i_rd & rst_n;
    d_req      = (d_rd | d_wr) & rst_n;
    i_fault    = i_seg_fault;
    d_fault    = d_seg_fault | (d_rd & d_wr);
    i_hit      = i_req && !i_fault && ibuf.valid && (ibuf.trd == i_trd) && (ibuf.vaddr == i_addr);
    d_hit      = d_req && !d_fault && dbuf.valid && (dbuf.trd == d_trd) && (dbuf.vaddr == d_addr)
                 && (dbuf_we == d_wr) && (!d_wr || (dbuf_wdata == d_wr_data));
    i_segfault = i_req & i_fault;
    d_segfault = d_req & d_fault;
    i_miss     = i_req & !i_fault & !i_hit;
    d_miss     = d_req & !d_fault & !d_hit;
    d_launch   = (state == IDLE) & d_miss;
    i_launch   = (state == IDLE) & i_miss & !d_miss;
    i_kill     = drop | (cfg_wr & (cfg_trd == ibuf.trd));
    d_kill     = drop | (cfg_wr & (cfg_trd == dbuf.trd));
    ext_req    = (state != IDLE);
  end

  // Next state and drop flag; a launch in the config-write cycle is already stale.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (d_launch) state_nxt = D_BUSY;
               else if (i_launch) state_nxt = I_BUSY;
      I_BUSY,
      D_BUSY:  if (ext_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    drop_nxt = drop | (cfg_wr & ((i_launch & (i_trd == cfg_trd)) |
                                 (d_launch & (d_trd == cfg_trd)) |
                                 ((state == I_BUSY) & (ibuf.trd == cfg_trd)) |
                                 ((state == D_BUSY) & (dbuf.trd == cfg_trd))));
    if (state_nxt == IDLE) drop_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drop      <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (d_launch) begin
        ext_we    <= d_wr;
        ext_addr  <= d_phys;
        ext_wdata <= d_wr_data;
      end else if (i_launch) begin
        ext_we    <= 1'b0;
        ext_addr  <= i_phys;
        ext_wdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibuf <= '0;
    end else if (i_launch) begin
      ibuf <= '{valid: 1'b0, trd: i_trd, vaddr: i_addr, data: ibuf.data};
    end else if ((state == I_BUSY) && ext_ack && !i_kill) begin
      ibuf.data  <= ext_rdata;
      ibuf.valid <= 1'b1;
    end else if (i_hit || (cfg_wr && (cfg_trd == ibuf.trd))) begin
      ibuf.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbuf       <= '0;
      dbuf_we    <= 1'b0;
      dbuf_wdata <= '0;
    end else if (d_launch) begin
      dbuf       <= '{valid: 1'b0, trd: d_trd, vaddr: d_addr, data: dbuf.data};
      dbuf_we    <= d_wr;
      dbuf_wdata <= d_wr_data;
    end else if ((state == D_BUSY) && ext_ack && !d_kill) begin
      dbuf.data  <= ext_rdata;
      dbuf.valid <= 1'b1;
    end else if (d_hit || (cfg_wr && (cfg_trd == dbuf.trd))) begin
      dbuf.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rd_data <= '0;
      d_rd_data <= '0;
    end else begin
      if (i_hit) i_rd_data <= ibuf.data;
      if (d_hit && !d_wr) d_rd_data <= dbuf.data;
    end
  end

endmodule

// File: tb/tb_threadkraken_mmu.sv
// Directed bench for threadkraken_mmu.
module tb_threadkraken_mmu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr, i_rd_data;
  logic        i_rd, i_miss, i_segfault;
  logic [2:0]  i_trd;
  logic [31:0] d_addr, d_wr_data, d_rd_data;
  logic        d_rd, d_wr, d_miss, d_segfault;
  logic [2:0]  d_trd;
  logic        cfg_wr, cfg_valid;
  logic [2:0]  cfg_trd;
  logic [31:0] cfg_base, cfg_limit;
  logic        ext_req, ext_we, ext_ack;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;

  int n_total = 0;
  int n_bad   = 0;

  threadkraken_mmu #(.BOOT_LIMIT(32'hFFFF_FFFC)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd), .i_rd_data(i_rd_data),
    .i_miss(i_miss), .i_segfault(i_segfault),
    .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr), .d_trd(d_trd),
    .d_rd_data(d_rd_data), .d_miss(d_miss), .d_segfault(d_segfault),
    .cfg_wr(cfg_wr), .cfg_trd(cfg_trd), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .cfg_valid(cfg_valid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] trd, input logic [31:0] base, input logic [31:0] limit);
    cfg_wr = 1'b1; cfg_trd = trd; cfg_base = base; cfg_limit = limit; cfg_valid = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic ack(input logic [31:0] data);
    ext_ack = 1'b1; ext_rdata = data;
    tick();
    ext_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_addr = '0; i_rd = 1'b0; i_trd = '0;
    d_addr = '0; d_wr_data = '0; d_rd = 1'b0; d_wr = 1'b0; d_trd = '0;
    cfg_wr = 1'b0; cfg_trd = '0; cfg_base = '0; cfg_limit = '0; cfg_valid = 1'b0;
    ext_ack = 1'b0; ext_rdata = '0;
    #12;
    chk("rst_i_miss", i_miss, 0);
    chk("rst_ext_req", ext_req, 0);
    chk("rst_ext_addr", ext_addr, 0);
    chk("rst_i_rd_data", i_rd_data, 0);
    chk("rst_d_rd_data", d_rd_data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // boot fetch
    i_rd = 1'b1; i_trd = 3'd0; i_addr = 32'h100;
    #1;
    chk("boot_miss", i_miss, 1);
    chk("boot_segf", i_segfault, 0);
    tick();
    chk("boot_req", ext_req, 1);
    chk("boot_addr", ext_addr, 32'h100);
    chk("boot_we", ext_we, 0);
    i_rd = 1'b0;
    ack(32'hDEADBEEF);
    chk("boot_req_fall", ext_req, 0);
    i_rd = 1'b1;
    #1;
    chk("boot_replay_miss", i_miss, 0);
    tick();
    i_rd = 1'b0;
    chk("boot_data", i_rd_data, 32'hDEADBEEF);
    tick();
    chk("boot_data_hold", i_rd_data, 32'hDEADBEEF);
    i_rd = 1'b1;
    #1;
    chk("boot_consumed", i_miss, 1);
    tick();
    i_rd = 1'b0;
    ack(32'h0);

    // segfaults
    cfg(3'd3, 32'h4000, 32'hFF);
    d_rd = 1'b1; d_trd = 3'd3; d_addr = 32'h100;
    #1;
    chk("seg_limit_f", d_segfault, 1);
    chk("seg_limit_m", d_miss, 0);
    tick();
    chk("seg_no_req", ext_req, 0);
    d_addr = 32'h2;
    #1;
    chk("seg_align", d_segfault, 1);
    d_addr = 32'h10;
    #1;
    chk("seg_ok_f", d_segfault, 0);
    chk("seg_ok_m", d_miss, 1);
    tick();
    chk("seg_xlate", ext_addr, 32'h4010);
    d_rd = 1'b0;
    ack(32'h1111_2222);
    d_rd = 1'b1;
    #1;
    chk("seg_replay", d_miss, 0);
    tick();
    d_rd = 1'b0;
    chk("seg_data", d_rd_data, 32'h1111_2222);
    i_rd = 1'b1; i_trd = 3'd5; i_addr = 32'h0;
    #1;
    chk("seg_invalid_f", i_segfault, 1);
    chk("seg_invalid_m", i_miss, 0);
    i_rd = 1'b0;
    d_rd = 1'b1; d_wr = 1'b1; d_trd = 3'd0; d_addr = 32'h40;
    #1;
    chk("rdwr_segf", d_segfault, 1);
    chk("rdwr_miss", d_miss, 0);
    tick();
    d_rd = 1'b0; d_wr = 1'b0;
    chk("rdwr_no_req", ext_req, 0);

    // arbitration
    i_rd = 1'b1; i_trd = 3'd0; i_addr = 32'h200;
    d_rd = 1'b1; d_trd = 3'd0; d_addr = 32'h300;
    #1;
    chk("arb_i_miss", i_miss, 1);
    chk("arb_d_miss", d_miss, 1);
    tick();
    chk("arb_d_first", ext_addr, 32'h300);
    chk("arb_busy_i_miss", i_miss, 1);
    ack(32'hAAAA_0000);
    chk("arb_d_hit", d_miss, 0);
    chk("arb_i_still", i_miss, 1);
    tick();
    chk("arb_i_launch", ext_addr, 32'h200);
    chk("arb_i_req", ext_req, 1);
    chk("arb_d_data", d_rd_data, 32'hAAAA_0000);
    d_rd = 1'b0; i_rd = 1'b0;
    ack(32'hBBBB_0000);
    i_rd = 1'b1;
    #1;
    chk("arb_i_hit", i_miss, 0);
    tick();
    i_rd = 1'b0;
    chk("arb_i_data", i_rd_data, 32'hBBBB_0000);

    // store
    d_wr = 1'b1; d_trd = 3'd0; d_addr = 32'h20; d_wr_data = 32'h5;
    #1;
    chk("st_miss", d_miss, 1);
    tick();
    chk("st_we", ext_we, 1);
    chk("st_wdata", ext_wdata, 32'h5);
    chk("st_addr", ext_addr, 32'h20);
    d_wr = 1'b0;
    ack(32'h0);
    d_wr = 1'b1; d_wr_data = 32'h6;
    #1;
    chk("st_diff_miss", d_miss, 1);
    tick();
    chk("st_relaunch", ext_wdata, 32'h6);
    d_wr = 1'b0;
    ack(32'h0);
    d_wr = 1'b1;
    #1;
    chk("st_same_hit", d_miss, 0);
    tick();
    d_wr = 1'b0;
    chk("st_no_data", d_rd_data, 32'hAAAA_0000);

    // config write racing ext_ack
    cfg(3'd2, 32'h8000, 32'hFFF);
    i_rd = 1'b1; i_trd = 3'd2; i_addr = 32'h40;
    #1;
    chk("race_miss", i_miss, 1);
    tick();
    chk("race_addr", ext_addr, 32'h8040);
    i_rd = 1'b0;
    cfg_wr = 1'b1; cfg_trd = 3'd2; cfg_base = 32'h8000; cfg_limit = 32'hFFF; cfg_valid = 1'b1;
    ack(32'h1234_5678);
    cfg_wr = 1'b0;
    chk("race_idle", ext_req, 0);
    i_rd = 1'b1;
    #1;
    chk("race_replay_miss", i_miss, 1);
    tick();
    chk("race_relaunch", ext_req, 1);

    // reset while I_BUSY
    rst_n = 1'b0;
    #1;
    chk("mrst_req", ext_req, 0);
    chk("mrst_addr", ext_addr, 0);
    chk("mrst_i_miss", i_miss, 0);
    chk("mrst_i_data", i_rd_data, 0);
    i_rd = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    i_rd = 1'b1; i_trd = 3'd0; i_addr = 32'h1000;
    #1;
    chk("post_rst_segf", i_segfault, 0);
    chk("post_rst_miss", i_miss, 1);
    tick();
    chk("post_rst_addr", ext_addr, 32'h1000);
    i_trd = 3'd2;
    #1;
    chk("post_rst_t2_inv", i_segfault, 1);
    i_rd = 1'b0;
    ack(32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
